out_port_serial_tx: RTL

- Serial transmitter for the 16-bit processor's output port.
- Each OutputWrite strobe from the processor pushes its 16-bit output word into a small FIFO.
- The block sends each word on a single UART-style line: start bit, 16 data bits LSB first, stop bit.
- It lets a bench or an external receiver see the processor's output stream without probing internal nets.

---
 rtl/out_port_serial_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/out_port_serial_tx.sv
// out_port_serial_tx: FIFO-buffered UART-style transmitter for the processor output port.
// Frame = start, 16 data bits LSB first, stop. Define OUT_PORT_TX_PARITY_EN for an even-parity bit before stop.
module out_port_serial_tx #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [15:0]                wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       busy,
  output logic                       tx
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

`ifdef OUT_PORT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;

  state_t        state;
  logic [15:0]   shift;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cyc_cnt;
`ifdef OUT_PORT_TX_PARITY_EN
  logic          par_bit;
`endif

  always_comb begin
    full  = (count == LVL_FULL);
    level = count;
    pop   = (state == IDLE) && (count != '0);
    // a pop in the same cycle frees the slot, so a push while full is still accepted
    push  = wr_en && (!full || pop);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // tx is registered from the current state, so the line trails the state by one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      busy    <= 1'b0;
      tx      <= 1'b1;
`ifdef OUT_PORT_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            cyc_cnt <= '0;
            busy    <= 1'b1;
            state   <= START;
`ifdef OUT_PORT_TX_PARITY_EN
            par_bit <= ^mem[rd_ptr];
`endif
          end
        end
        START: begin
          tx <= 1'b0;
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          tx <= shift[0];
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            shift   <= {1'b0, shift[15:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
`ifdef OUT_PORT_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
`ifdef OUT_PORT_TX_PARITY_EN
        PARITY: begin
          tx <= par_bit;
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
